// File: rtl/centroid_pkg.sv
// centroid_pkg: shared definitions for the centroid tracker.
//   - default parameter widths
//   - FSM state encoding (plain constants)
//   - sum_width(): width of the coordinate accumulators
package centroid_pkg;

    localparam int unsigned DEF_COLOR_WIDTH = 10;
    localparam int unsigned DEF_DISP_WIDTH  = 11;
    localparam int unsigned DEF_CNT_WIDTH   = 20;
    localparam int unsigned DEF_MIN_PIXELS  = 64;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t DIVIDE = 2'd1;
    localparam state_t UPDATE = 2'd2;

    // A sum of at most 2^cnt_w - 1 coordinates, each below 2^disp_w, fits here.
    function automatic int unsigned sum_width(input int unsigned disp_w,
                                              input int unsigned cnt_w);
        return disp_w + cnt_w;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider producing one quotient bit per cycle, MSB first.
// The caller guarantees the quotient fits in QUOT_WIDTH bits. A zero divisor
// yields an all-ones quotient.
// Ports:
//   clk, aresetn   clock, synchronous active-low reset
//   start          load the operands and begin (ignored bits are sampled later)
//   dividend       must stay stable from start until done
//   divisor        must stay stable from start until done
//   quotient       result, valid the cycle after done
//   done           high during the cycle whose edge captures the last bit
module seq_divider #(
    parameter int unsigned DIVIDEND_WIDTH = 31,
    parameter int unsigned DIVISOR_WIDTH  = 20,
    parameter int unsigned QUOT_WIDTH     = 11
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic [QUOT_WIDTH-1:0]     quotient,
    output logic                      done
);

    localparam int unsigned IDX_WIDTH = (QUOT_WIDTH > 1) ? $clog2(QUOT_WIDTH) : 1;

    logic                     running_q;
    logic [IDX_WIDTH-1:0]     idx_q;
    logic [DIVISOR_WIDTH-1:0] rem_q;
    logic [QUOT_WIDTH-1:0]    quot_q;

    logic [QUOT_WIDTH-1:0]    low_bits;
    logic [DIVISOR_WIDTH:0]   rem_shift;
    logic                     ge;

    // Dividend bits below the quotient width are brought down one per step;
    // the bits above them seed the remainder, which is already < divisor
    // because the quotient fits.
    always_comb begin
        low_bits  = dividend[QUOT_WIDTH-1:0];
        rem_shift = {rem_q, low_bits[idx_q]};
        ge        = rem_shift >= {1'b0, divisor};
    end

    assign done     = running_q && (idx_q == '0);
    assign quotient = quot_q;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            running_q <= 1'b0;
            idx_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
        end else if (start) begin
            running_q <= 1'b1;
            idx_q     <= IDX_WIDTH'(QUOT_WIDTH - 1);
            rem_q     <= DIVISOR_WIDTH'(dividend >> QUOT_WIDTH);
            quot_q    <= '0;
        end else if (running_q) begin
            rem_q  <= ge ? DIVISOR_WIDTH'(rem_shift - {1'b0, divisor})
                         : rem_shift[DIVISOR_WIDTH-1:0];
            quot_q <= {quot_q[QUOT_WIDTH-2:0], ge};
            idx_q  <= idx_q - IDX_WIDTH'(1);
            if (idx_q == '0) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/centroid_tracker.sv
// centroid_tracker: per-frame centroid of pixels matching colour thresholds.
// Matching pixels are accumulated (count, sum x, sum y); at frame_end the
// totals are snapshotted and divided while the next frame accumulates.
// Optional build macro: CENTROID_SMOOTH_EN enables a 1/4-step IIR filter on
// the reported coordinates.
// Ports:
//   clk, aresetn              clock, synchronous active-low reset
//   enable                    low forces no matches
//   pix_valid                 active-area pixel on red/green/blue/x_pos/y_pos
//   frame_end                 one-cycle pulse after the last pixel of a frame
//   red, green, blue          pixel colour
//   x_pos, y_pos              pixel coordinate
//   r_min, g_max, b_max       match thresholds
//   x_obj, y_obj              centroid of the last valid frame
//   obj_valid                 last completed frame held a valid object
//   update                    one-cycle pulse when outputs refresh
//   busy                      divide in progress
//   overrun                   one-cycle pulse when a frame is dropped
module centroid_tracker
    import centroid_pkg::*;
#(
    parameter int unsigned COLOR_WIDTH = DEF_COLOR_WIDTH,
    parameter int unsigned DISP_WIDTH  = DEF_DISP_WIDTH,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int unsigned MIN_PIXELS  = DEF_MIN_PIXELS
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   enable,
    input  logic                   pix_valid,
    input  logic                   frame_end,
    input  logic [COLOR_WIDTH-1:0] red,
    input  logic [COLOR_WIDTH-1:0] green,
    input  logic [COLOR_WIDTH-1:0] blue,
    input  logic [DISP_WIDTH-1:0]  x_pos,
    input  logic [DISP_WIDTH-1:0]  y_pos,
    input  logic [COLOR_WIDTH-1:0] r_min,
    input  logic [COLOR_WIDTH-1:0] g_max,
    input  logic [COLOR_WIDTH-1:0] b_max,
    output logic [DISP_WIDTH-1:0]  x_obj,
    output logic [DISP_WIDTH-1:0]  y_obj,
    output logic                   obj_valid,
    output logic                   update,
    output logic                   busy,
    output logic                   overrun
);

    localparam int unsigned SUM_WIDTH = sum_width(DISP_WIDTH, CNT_WIDTH);

    state_t                 state_q, state_d;

    logic                   match;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_n;
    logic [SUM_WIDTH-1:0]   sum_x_q, sum_x_n;
    logic [SUM_WIDTH-1:0]   sum_y_q, sum_y_n;
    logic                   sat_q, sat_n;

    logic [CNT_WIDTH-1:0]   snap_cnt_q;
    logic [SUM_WIDTH-1:0]   snap_sum_x_q, snap_sum_y_q;
    logic                   snap_sat_q;
    logic                   snap_load;

    logic [SUM_WIDTH-1:0]   div_sum_x, div_sum_y;
    logic [CNT_WIDTH-1:0]   div_cnt;
    logic [DISP_WIDTH-1:0]  quot_x, quot_y;
    logic                   done_x, done_y;

    logic                   obj_ok;
    logic [DISP_WIDTH-1:0]  x_upd, y_upd;

    logic [DISP_WIDTH-1:0]  x_obj_q, y_obj_q;
    logic                   obj_valid_q, update_q, overrun_q;

`ifdef CENTROID_SMOOTH_EN
    // cur + (nxt - cur) / 4, arithmetic shift on a one-bit-wider signed difference
    function automatic logic [DISP_WIDTH-1:0] smooth(input logic [DISP_WIDTH-1:0] cur,
                                                     input logic [DISP_WIDTH-1:0] nxt);
        logic signed [DISP_WIDTH:0] diff;
        diff = $signed({1'b0, nxt}) - $signed({1'b0, cur});
        return DISP_WIDTH'($signed({1'b0, cur}) + (diff >>> 2));
    endfunction
`endif

    // Accumulator next values including this cycle's pixel.
    always_comb begin
        match   = enable & pix_valid & (red >= r_min) & (green <= g_max) & (blue <= b_max);
        cnt_n   = cnt_q;
        sum_x_n = sum_x_q;
        sum_y_n = sum_y_q;
        sat_n   = sat_q;
        if (match && !sat_q) begin
            if (&cnt_q) begin
                sat_n = 1'b1;
            end else begin
                cnt_n   = cnt_q + CNT_WIDTH'(1);
                sum_x_n = sum_x_q + SUM_WIDTH'(x_pos);
                sum_y_n = sum_y_q + SUM_WIDTH'(y_pos);
            end
        end
    end

    assign snap_load = frame_end && (state_q == IDLE);

    // On the load edge the snapshot registers are not yet written, so feed the
    // dividers the values being captured; afterwards they read the snapshot.
    assign div_sum_x = snap_load ? sum_x_n : snap_sum_x_q;
    assign div_sum_y = snap_load ? sum_y_n : snap_sum_y_q;
    assign div_cnt   = snap_load ? cnt_n   : snap_cnt_q;

    seq_divider #(
        .DIVIDEND_WIDTH (SUM_WIDTH),
        .DIVISOR_WIDTH  (CNT_WIDTH),
        .QUOT_WIDTH     (DISP_WIDTH)
    ) u_div_x (
        .clk      (clk),
        .aresetn  (aresetn),
        .start    (snap_load),
        .dividend (div_sum_x),
        .divisor  (div_cnt),
        .quotient (quot_x),
        .done     (done_x)
    );

    seq_divider #(
        .DIVIDEND_WIDTH (SUM_WIDTH),
        .DIVISOR_WIDTH  (CNT_WIDTH),
        .QUOT_WIDTH     (DISP_WIDTH)
    ) u_div_y (
        .clk      (clk),
        .aresetn  (aresetn),
        .start    (snap_load),
        .dividend (div_sum_y),
        .divisor  (div_cnt),
        .quotient (quot_y),
        .done     (done_y)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_end) state_d = DIVIDE;
            DIVIDE:  if (done_x && done_y) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        obj_ok = (snap_cnt_q >= CNT_WIDTH'(MIN_PIXELS)) && !snap_sat_q;
`ifdef CENTROID_SMOOTH_EN
        x_upd  = obj_valid_q ? smooth(x_obj_q, quot_x) : quot_x;
        y_upd  = obj_valid_q ? smooth(y_obj_q, quot_y) : quot_y;
`else
        x_upd  = quot_x;
        y_upd  = quot_y;
`endif
    end

    // Accumulators and snapshot.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            cnt_q        <= '0;
            sum_x_q      <= '0;
            sum_y_q      <= '0;
            sat_q        <= 1'b0;
            snap_cnt_q   <= '0;
            snap_sum_x_q <= '0;
            snap_sum_y_q <= '0;
            snap_sat_q   <= 1'b0;
        end else begin
            // frame_end always restarts collection; the pixel in that cycle
            // belongs to the ending frame (or is lost with it on overrun).
            if (frame_end) begin
                cnt_q   <= '0;
                sum_x_q <= '0;
                sum_y_q <= '0;
                sat_q   <= 1'b0;
            end else begin
                cnt_q   <= cnt_n;
                sum_x_q <= sum_x_n;
                sum_y_q <= sum_y_n;
                sat_q   <= sat_n;
            end
            if (snap_load) begin
                snap_cnt_q   <= cnt_n;
                snap_sum_x_q <= sum_x_n;
                snap_sum_y_q <= sum_y_n;
                snap_sat_q   <= sat_n;
            end
        end
    end

    // Control and outputs.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            x_obj_q     <= '0;
            y_obj_q     <= '0;
            obj_valid_q <= 1'b0;
            update_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= frame_end && (state_q != IDLE);
            update_q  <= (state_q == UPDATE);
            if (state_q == UPDATE) begin
                obj_valid_q <= obj_ok;
                if (obj_ok) begin
                    x_obj_q <= x_upd;
                    y_obj_q <= y_upd;
                end
            end
        end
    end

    assign x_obj     = x_obj_q;
    assign y_obj     = y_obj_q;
    assign obj_valid = obj_valid_q;
    assign update    = update_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_centroid_tracker.sv
module tb_centroid_tracker;

    localparam int unsigned CW   = 10;
    localparam int unsigned DW   = 11;
    localparam int unsigned NW   = 20;
    localparam int unsigned MINP = 16;

    logic          clk = 1'b0;
    logic          aresetn, enable, pix_valid, frame_end;
    logic [CW-1:0] red, green, blue, r_min, g_max, b_max;
    logic [DW-1:0] x_pos, y_pos, x_obj, y_obj;
    logic          obj_valid, update, busy, overrun;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-frame totals of matching pixels and expected outputs.
    longint m_cnt, m_sx, m_sy;
    longint s_cnt, s_sx, s_sy;
    int     e_x, e_y;
    bit     e_valid;

    always #5 clk = ~clk;

    centroid_tracker #(
        .COLOR_WIDTH (CW),
        .DISP_WIDTH  (DW),
        .CNT_WIDTH   (NW),
        .MIN_PIXELS  (MINP)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .enable    (enable),
        .pix_valid (pix_valid),
        .frame_end (frame_end),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .r_min     (r_min),
        .g_max     (g_max),
        .b_max     (b_max),
        .x_obj     (x_obj),
        .y_obj     (y_obj),
        .obj_valid (obj_valid),
        .update    (update),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_sx  = 0;
        m_sy  = 0;
    endtask

    // Drive one pixel onto the inputs and account for it in the model.
    task automatic set_pix(input bit pv, input int r, input int g, input int b,
                           input int x, input int y);
        pix_valid = pv;
        red       = CW'(r);
        green     = CW'(g);
        blue      = CW'(b);
        x_pos     = DW'(x);
        y_pos     = DW'(y);
        if (pv && enable && r >= int'(r_min) && g <= int'(g_max) && b <= int'(b_max)) begin
            m_cnt += 1;
            m_sx  += x;
            m_sy  += y;
        end
    endtask

    task automatic pixel(input bit pv, input int r, input int g, input int b,
                         input int x, input int y);
        set_pix(pv, r, g, b, x, y);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic rand_pix();
        set_pix($urandom_range(0, 3) != 0, $urandom_range(400, 1023), $urandom_range(0, 400),
                $urandom_range(0, 400), $urandom_range(0, 2047), $urandom_range(0, 2047));
    endtask

    task automatic noise_pix();
        pixel(1'b1, $urandom_range(0, 511), $urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 2047), $urandom_range(0, 2047));
    endtask

    // First n pixels of the 4x4 red block at x 100..103, y 50..53.
    task automatic block(input int n);
        pixel(1'b0, 1023, 0, 0, 7, 7);
        for (int k = 0; k < n; k++) begin
            pixel(1'b1, 1023, 0, 0, 100 + (k % 4), 50 + (k / 4));
            noise_pix();
        end
    endtask

    task automatic column(input int c);
        for (int k = 0; k < 16; k++) begin
            pixel(1'b1, 1023, 0, 0, c, c);
            noise_pix();
        end
    endtask

    task automatic end_frame(input bit with_pix, input int x, input int y);
        if (with_pix) set_pix(1'b1, 1023, 0, 0, x, y);
        else pix_valid = 1'b0;
        frame_end = 1'b1;
        s_cnt = m_cnt;
        s_sx  = m_sx;
        s_sy  = m_sy;
        model_clear();
        tick();
        frame_end = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic model_update();
        int nx, ny;
        if (s_cnt >= MINP) begin
            nx = int'(s_sx / s_cnt);
            ny = int'(s_sy / s_cnt);
`ifdef CENTROID_SMOOTH_EN
            if (e_valid) begin
                e_x = e_x + ((nx - e_x) >>> 2);
                e_y = e_y + ((ny - e_y) >>> 2);
            end else begin
                e_x = nx;
                e_y = ny;
            end
`else
            e_x = nx;
            e_y = ny;
`endif
            e_valid = 1'b1;
        end else begin
            e_valid = 1'b0;
        end
    endtask

    // Called right after the edge that sampled frame_end (E0).
    task automatic run_divide(input int ovr_at, input bit noisy);
        int early;
        early = 0;
        check("busy_e0", busy, 1);
        for (int i = 1; i <= 13; i++) begin
            if (noisy) rand_pix();
            else pix_valid = 1'b0;
            frame_end = (i == ovr_at);
            if (i == ovr_at) model_clear();
            tick();
            frame_end = 1'b0;
            pix_valid = 1'b0;
            if (i == ovr_at) check("overrun_pulse", overrun, 1);
            else if (i == ovr_at + 1) check("overrun_quiet", overrun, 0);
            if (i < 12) begin
                if (update !== 1'b0 || busy !== 1'b1) early++;
            end else if (i == 12) begin
                model_update();
                check("update_pulse", update, 1);
                check("busy_done", busy, 0);
                check("obj_valid", obj_valid, e_valid);
                check("x_obj", x_obj, e_x);
                check("y_obj", y_obj, e_y);
            end else begin
                check("update_one_cycle", update, 0);
            end
        end
        check("divide_window", early, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, x_obj, 0);
        check({tag, "_y"}, y_obj, 0);
        check({tag, "_valid"}, obj_valid, 0);
        check({tag, "_update"}, update, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int upd_cnt;
        aresetn   = 1'b0;
        enable    = 1'b1;
        pix_valid = 1'b0;
        frame_end = 1'b0;
        red = '0; green = '0; blue = '0; x_pos = '0; y_pos = '0;
        r_min = CW'(512);
        g_max = CW'(256);
        b_max = CW'(256);
        model_clear();
        s_cnt = 0; s_sx = 0; s_sy = 0;
        e_x = 0; e_y = 0; e_valid = 1'b0;

        tick();
        tick();
        check_reset_outputs("reset");
        aresetn = 1'b1;
        tick();

        // Block centroid: floor(1624/16)=101, floor(824/16)=51.
        block(16);
        end_frame(1'b0, 0, 0);
        run_divide(0, 1'b0);
        check("block_x_const", x_obj, 101);
        check("block_y_const", y_obj, 51);

        // Too few pixels: result invalid, coordinates held.
        block(15);
        end_frame(1'b0, 0, 0);
        run_divide(0, 1'b0);
        check("few_valid_const", obj_valid, 0);
        check("few_x_held", x_obj, 101);

        // Enable low for the whole frame.
        enable = 1'b0;
        block(16);
        end_frame(1'b0, 0, 0);
        enable = 1'b1;
        run_divide(0, 1'b0);
        check("enable_low_valid", obj_valid, 0);

        // Two frames with centroids 100 then 140, starting from obj_valid=0.
        column(100);
        end_frame(1'b0, 0, 0);
        run_divide(0, 1'b0);
        check("first_col_x", x_obj, 100);
        column(140);
        end_frame(1'b0, 0, 0);
        run_divide(0, 1'b0);
`ifdef CENTROID_SMOOTH_EN
        check("second_col_x", x_obj, 110);
`else
        check("second_col_x", x_obj, 140);
`endif

        // Boundary pixel at (200,200) sampled together with frame_end.
        enable = 1'b0;
        block(4);
        end_frame(1'b0, 0, 0);
        enable = 1'b1;
        run_divide(0, 1'b0);
        block(16);
        end_frame(1'b1, 200, 200);
        run_divide(0, 1'b0);
        check("boundary_x_const", x_obj, 107);
        check("boundary_y_const", y_obj, 60);
        block(16);
        end_frame(1'b0, 0, 0);
        run_divide(0, 1'b0);

        // Random frames, with pixels also arriving during each divide.
        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(30, 90);
            for (int k = 0; k < n; k++) begin
                rand_pix();
                tick();
                pix_valid = 1'b0;
            end
            end_frame($urandom_range(0, 1) == 1, $urandom_range(0, 2047),
                      $urandom_range(0, 2047));
            run_divide(0, 1'b1);
        end

        // Overrun: second frame_end five cycles after the first.
        block(16);
        end_frame(1'b0, 0, 0);
        run_divide(5, 1'b1);
        for (int k = 0; k < 40; k++) begin
            rand_pix();
            tick();
            pix_valid = 1'b0;
        end
        end_frame(1'b0, 0, 0);
        run_divide(0, 1'b0);

        // Reset during the sixth DIVIDE cycle.
        block(16);
        end_frame(1'b0, 0, 0);
        for (int k = 0; k < 5; k++) tick();
        aresetn = 1'b0;
        tick();
        check_reset_outputs("midreset");
        aresetn = 1'b1;
        model_clear();
        e_x = 0; e_y = 0; e_valid = 1'b0;
        upd_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (update === 1'b1) upd_cnt++;
        end
        check("midreset_no_update", upd_cnt, 0);
        check("midreset_x_after", x_obj, 0);
        block(16);
        end_frame(1'b0, 0, 0);
        run_divide(0, 1'b0);
        check("post_reset_x_const", x_obj, 101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
